// File: rtl/scoreboard_pkg.sv
// Shared constants for the BCD up/down scoreboard: FSM encodings and
// active-high gfedcba segment patterns for the decimal digits.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_CLEARED = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;

endpackage

// File: rtl/bcd_seg7_dec.sv
// One BCD digit to active-high gfedcba segments; non-decimal codes blank.
module bcd_seg7_dec
    import scoreboard_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/bcd_updown_scoreboard.sv
// Multi-digit BCD up/down score counter with edge-detected buttons,
// saturate/wrap boundary handling, long-press clear and 7-segment outputs.
module bcd_updown_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int CLR_HOLD = 5,
    parameter int WRAP     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg7,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [7:0] HOLD_LAST = 8'(CLR_HOLD - 1);

    state_t              state, state_nx;
    logic [7:0]          hold_cnt, hold_cnt_nx;
    logic [4*DIGITS-1:0] count, count_nx;
    logic                inc_q, dec_q;
    logic                inc_ev, dec_ev;

    logic [4*DIGITS-1:0] count_up, count_dn;
    logic [DIGITS:0]     carry, borrow;

    assign inc_ev = inc & ~inc_q;
    assign dec_ev = dec & ~dec_q;

    // Ripple chains: carry[k] means every lower digit is 9, borrow[k] every lower digit is 0.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] d;
        assign d           = count[4*k +: 4];
        assign carry[k+1]  = carry[k]  & (d == BCD_NINE);
        assign borrow[k+1] = borrow[k] & (d == 4'd0);
        assign count_up[4*k +: 4] = !carry[k]  ? d : ((d == BCD_NINE) ? 4'd0 : d + 4'd1);
        assign count_dn[4*k +: 4] = !borrow[k] ? d : ((d == 4'd0) ? BCD_NINE : d - 4'd1);

        bcd_seg7_dec u_dec (
            .bcd (d),
            .seg (seg7[7*k +: 7])
        );
    end

    assign at_max = carry[DIGITS];
    assign at_min = borrow[DIGITS];
    assign bcd    = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            hold_cnt <= 8'd0;
            count    <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            count    <= count_nx;
            inc_q    <= inc;
            dec_q    <= dec;
        end
    end

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        count_nx    = count;
        case (state)
            ST_RUN: begin
                if (clr) begin
                    state_nx    = ST_HOLD;
                    hold_cnt_nx = 8'd1;
                end else if (inc_ev && !dec_ev) begin
                    if (!(at_max && WRAP == 0)) count_nx = count_up;
                end else if (dec_ev && !inc_ev) begin
                    if (!(at_min && WRAP == 0)) count_nx = count_dn;
                end
            end
            ST_HOLD: begin
                if (!clr) begin
                    state_nx    = ST_RUN;
                    hold_cnt_nx = 8'd0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx    = ST_CLEARED;
                    hold_cnt_nx = 8'd0;
                    count_nx    = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + 8'd1;
                end
            end
            ST_CLEARED: begin
                if (!clr) state_nx = ST_RUN;
            end
            default: begin
                state_nx    = ST_RUN;
                hold_cnt_nx = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_updown_scoreboard.sv
// Directed bench: a saturating and a wrapping instance share the same button stimulus.
module tb_bcd_updown_scoreboard;

    logic        clk = 1'b0;
    logic        rst, inc, dec, clr;
    logic [7:0]  bcd0, bcd1;
    logic [13:0] seg0, seg1;
    logic        max0, min0, max1, min1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_updown_scoreboard #(.DIGITS(2), .CLR_HOLD(5), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr),
        .bcd(bcd0), .seg7(seg0), .at_max(max0), .at_min(min0)
    );

    bcd_updown_scoreboard #(.DIGITS(2), .CLR_HOLD(5), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr),
        .bcd(bcd1), .seg7(seg1), .at_max(max1), .at_min(min1)
    );

    typedef struct {
        logic       inc;
        logic       dec;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; inc = 1'b0; dec = 1'b0; clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc = 1'b1; step();
            inc = 1'b0; step();
        end
    endtask

    task automatic pulse_dec();
        dec = 1'b1; step();
        dec = 1'b0; step();
    endtask

    initial begin
        // Starting from 00 after reset; each row is one clock edge.
        vecs[0]  = '{1'b1, 1'b0, 8'h01, 8'h01};
        vecs[1]  = '{1'b1, 1'b0, 8'h01, 8'h01};
        vecs[2]  = '{1'b0, 1'b0, 8'h01, 8'h01};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h99};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h99};
        vecs[7]  = '{1'b1, 1'b1, 8'h00, 8'h99};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h99};
        vecs[9]  = '{1'b1, 1'b0, 8'h01, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 8'h01, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h99};

        do_reset();
        check("reset_bcd", 32'(bcd0), 32'h00);
        check("reset_seg", 32'(seg0), 32'({7'b0111111, 7'b0111111}));
        check("reset_min", 32'(min0), 32'd1);
        check("reset_max", 32'(max0), 32'd0);
        check("reset_state", 32'(dut0.state), 32'd0);

        for (int i = 0; i < 12; i++) begin
            inc = vecs[i].inc;
            dec = vecs[i].dec;
            step();
            check($sformatf("vec%0d_sat", i), 32'(bcd0), 32'(vecs[i].exp0));
            check($sformatf("vec%0d_wrap", i), 32'(bcd1), 32'(vecs[i].exp1));
            check($sformatf("vec%0d_min", i), 32'(min0), 32'(vecs[i].exp0 == 8'h00));
            check($sformatf("vec%0d_max1", i), 32'(max1), 32'(vecs[i].exp1 == 8'h99));
        end
        inc = 1'b0; dec = 1'b0;

        // Twelve separate presses
        do_reset();
        pulse_inc(12);
        check("twelve_bcd", 32'(bcd0), 32'h12);
        check("twelve_seg_hi", 32'(seg0[13:7]), 32'(7'b0000110));
        check("twelve_seg_lo", 32'(seg0[6:0]), 32'(7'b1011011));

        // A held button counts once
        inc = 1'b1;
        for (int i = 0; i < 10; i++) step();
        inc = 1'b0; step();
        check("held_inc", 32'(bcd0), 32'h13);

        // Upper boundary in both modes
        do_reset();
        pulse_inc(99);
        check("ninetynine", 32'(bcd0), 32'h99);
        check("ninetynine_max", 32'(max0), 32'd1);
        check("ninetynine_seg", 32'(seg0), 32'({7'b1101111, 7'b1101111}));
        pulse_inc(1);
        check("sat_hold", 32'(bcd0), 32'h99);
        check("sat_max", 32'(max0), 32'd1);
        check("wrap_zero", 32'(bcd1), 32'h00);
        check("wrap_min", 32'(min1), 32'd1);
        pulse_dec();
        check("sat_dec", 32'(bcd0), 32'h98);
        check("wrap_dec", 32'(bcd1), 32'h99);

        // Simultaneous rising edges, then a borrow across digits
        do_reset();
        pulse_inc(45);
        inc = 1'b1; dec = 1'b1; step();
        inc = 1'b0; dec = 1'b0; step();
        check("both_edges", 32'(bcd0), 32'h45);
        do_reset();
        pulse_inc(10);
        pulse_dec();
        check("borrow", 32'(bcd0), 32'h09);
        check("borrow_seg", 32'(seg0), 32'({7'b0111111, 7'b1101111}));

        // Long-press clear
        do_reset();
        pulse_inc(37);
        clr = 1'b1;
        for (int i = 0; i < 4; i++) step();
        clr = 1'b0; step(); step();
        check("short_clr", 32'(bcd0), 32'h37);
        clr = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("clr_4th_edge", 32'(bcd0), 32'h37);
        step();
        check("clr_5th_edge", 32'(bcd0), 32'h00);
        pulse_inc(10);
        check("clr_held", 32'(bcd0), 32'h00);
        check("clr_held_wrap", 32'(bcd1), 32'h00);
        clr = 1'b0; step();
        pulse_inc(1);
        check("after_clr", 32'(bcd0), 32'h01);

        // Reset in the middle of a hold
        do_reset();
        pulse_inc(21);
        clr = 1'b1; step(); step();
        check("hold_before_rst", 32'(bcd0), 32'h21);
        rst = 1'b1; step();
        check("rst_mid_hold_bcd", 32'(bcd0), 32'h00);
        check("rst_mid_hold_state", 32'(dut0.state), 32'd0);
        rst = 1'b0; step();
        check("hold_restart", 32'(dut0.hold_cnt), 32'd1);
        clr = 1'b0; step();

        // An inc already high across reset counts once
        rst = 1'b1; inc = 1'b1; step();
        rst = 1'b0; step();
        check("inc_through_rst", 32'(bcd0), 32'h01);
        step(); step();
        check("inc_through_rst_once", 32'(bcd0), 32'h01);
        inc = 1'b0; step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_scoreboard.md
# bcd_updown_scoreboard

Parametrised multi-digit BCD up/down score counter with edge-triggered increment/decrement, saturate or wrap-around mode, long-press clear, and per-digit 7-segment decode. It sits between the debounced push-button inputs and the 7-segment display pins. It replaces the fixed two-digit, level-sensitive scoreboard.

## Interface
- DIGITS, 2: number of BCD digits (1..8); digit 0 is least significant.
- CLR_HOLD, 5: consecutive cycles `clr` must be sampled high before the count clears (2..255).
- WRAP, 0: 0 = saturate at 0 and at all-nines; 1 = wrap modulo 10^DIGITS.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inc  in  1  increment request; acts on its rising edge.
- dec  in  1  decrement request; acts on its rising edge.
- clr  in  1  long-press clear request; level, held.
- bcd  out  4*DIGITS  count; digit k is bcd[4k+3:4k].
- seg7  out  7*DIGITS  segments; digit k is seg7[7k+6:7k], order gfedcba, active-high.
- at_max  out  1  high when every digit is 9.
- at_min  out  1  high when every digit is 0.

## Operation
- Edge detection:
  - Registers inc_q and dec_q hold the previous samples.
  - inc_ev = inc & ~inc_q; dec_ev = dec & ~dec_q.
  - A held button counts once.
- State machine, 2-bit:
  - RUN: count on events. If clr = 1, go to HOLD with hold_cnt = 1.
  - HOLD: if clr = 0, return to RUN with hold_cnt = 0. Else if hold_cnt == CLR_HOLD-1, set bcd to 0 and go to CLEARED. Else hold_cnt+1.
  - CLEARED: stay while clr = 1. Go to RUN when clr = 0. This gives one clear per press.
- inc_ev and dec_ev are ignored in HOLD and CLEARED. inc_q and dec_q still update every cycle.
- RUN counting:
  - inc_ev & ~dec_ev: +1.
  - dec_ev & ~inc_ev: -1.
  - Both events together: no change.
- Arithmetic:
  - Per-digit BCD ripple. Increment: digit 9 becomes 0 with carry. Decrement: digit 0 becomes 9 with borrow.
  - Boundary: at all-nines, +1 holds (WRAP=0) or gives all-zeros (WRAP=1). At all-zeros, -1 holds (WRAP=0) or gives all-nines (WRAP=1).
- Decode table (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Codes 10–15 give 0000000; these are unreachable.
- Reset values:
  - bcd = 0, hence seg7 = DIGITS copies of 0111111.
  - at_min = 1, at_max = 0.
  - state = RUN, hold_cnt = 0, inc_q = dec_q = 0.
- rst has priority over everything, including mid-HOLD. After reset, an inc already high counts once on the first edge, because inc_q resets to 0.

## Timing
- Event at edge N (inc = 1 sampled, inc_q = 0): bcd updates at edge N, i.e. visible one cycle after the input is presented.
- seg7, at_max and at_min are combinational from the bcd register, so there is no extra latency.
- Clear: with clr high at edges N..N+CLR_HOLD-1, bcd = 0 after edge N+CLR_HOLD-1.
- A clr pulse shorter than CLR_HOLD cycles has no effect on the count. Events during that pulse are lost.

## Structure
- Package scoreboard_pkg holds:
  - state encodings ST_RUN = 2'd0, ST_HOLD = 2'd1, ST_CLEARED = 2'd2;
  - the ten segment constants;
  - BCD_NINE = 4'd9.
- Sub-module bcd_seg7_dec: 4-bit BCD to 7-bit segments, combinational. It is instantiated DIGITS times in a generate loop.
- The carry/borrow chain is a generate loop in the top block.
- hold_cnt is 8 bits wide.

## Test plan
- Reset then 12 separate inc pulses (DIGITS=2): bcd = 8'h12, seg7[13:7] = 0000110, seg7[6:0] = 1011011.
- inc held high for 10 cycles: bcd increments exactly once.
- From 8'h99, inc pulse with WRAP=0: stays 8'h99 and at_max = 1. With WRAP=1: 8'h00 and at_min = 1. From 8'h00, dec pulse with WRAP=1: 8'h99.
- inc and dec rising on the same edge at 8'h45: stays 8'h45. From 8'h10, dec gives 8'h09 (borrow).
- CLR_HOLD=5, count 8'h37:
  - clr high 4 cycles then low: still 8'h37.
  - clr high 5 cycles: 8'h00 after the 5th edge.
  - clr kept high 20 more cycles with inc pulses: stays 8'h00.
  - clr low, then inc: 8'h01.
- rst asserted mid-HOLD at count 8'h21: bcd = 0, state RUN. Releasing rst with clr high restarts hold_cnt from 1.
